// File: rtl/feeder_sched.sv
// feeder_sched
//   Layer-level sequencer for the feeder. Accepts one layer descriptor per
//   valid/ready handshake, holds the feeder configuration stable for the
//   whole layer, and streams in_cols*in_cols*chans*batch words from source
//   memory into the feeder. It honours fd_ram_full backpressure, waits for
//   fd_last_out, and then pulses done.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_valid/cfg_ready      descriptor handshake
//   cfg_stride..cfg_base     layer descriptor fields
//   src_rd_en/src_addr       source read request
//   src_data                 source read data, valid one cycle after src_rd_en
//   fd_start                 feeder start, high through LOAD and WAIT
//   fd_valid_write           feeder write strobe
//   fd_data_in               feeder write data
//   fd_ram_full              feeder full; no writes or reads while high
//   fd_last_out              feeder final output cycle
//   fd_stride..fd_o_dimension latched layer configuration
//   busy                     sequencer is not idle
//   done                     one-cycle layer completion pulse
//   err                      oversize layer or early fd_last_out, sticky
//   words_loaded             feeder writes issued for the current layer
module feeder_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int STREAM_W   = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [1:0]                     cfg_stride,
    input  logic [ADDR_WIDTH-1:0]          cfg_chans,
    input  logic [ADDR_WIDTH-1:0]          cfg_in_cols,
    input  logic [ADDR_WIDTH-1:0]          cfg_k,
    input  logic [ADDR_WIDTH-1:0]          cfg_o,
    input  logic [7:0]                     cfg_batch,
    input  logic [ADDR_WIDTH-1:0]          cfg_base,
    output logic                           src_rd_en,
    output logic [ADDR_WIDTH-1:0]          src_addr,
    input  logic [DATA_WIDTH*STREAM_W-1:0] src_data,
    output logic                           fd_start,
    output logic                           fd_valid_write,
    output logic [DATA_WIDTH*STREAM_W-1:0] fd_data_in,
    input  logic                           fd_ram_full,
    input  logic                           fd_last_out,
    output logic [1:0]                     fd_stride,
    output logic [ADDR_WIDTH-1:0]          fd_chans_per_mem,
    output logic [ADDR_WIDTH-1:0]          fd_in_cols,
    output logic [ADDR_WIDTH-1:0]          fd_k_dimension,
    output logic [ADDR_WIDTH-1:0]          fd_o_dimension,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [ADDR_WIDTH:0]            words_loaded
);

    localparam int SW = DATA_WIDTH * STREAM_W;
    localparam int CW = ADDR_WIDTH + 1;
    // Full-width product of cols*cols*chans*batch can never overflow.
    localparam int PW = 3 * ADDR_WIDTH + 8;
    localparam logic [PW-1:0] MAX_WORDS = PW'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [7:0]            batch_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CW-1:0]         total;
    logic [CW-1:0]         rd_cnt;
    logic [CW-1:0]         wr_cnt;
    logic                  rd_vld_p1;
    logic                  skid_vld_p1;
    logic [SW-1:0]         skid_data_p1;
    logic [PW-1:0]         total_full;
    logic                  oversize;
    logic                  accept;

    function automatic logic [PW-1:0] layer_words(
        input logic [ADDR_WIDTH-1:0] cols,
        input logic [ADDR_WIDTH-1:0] chans,
        input logic [7:0]            batch
    );
        return PW'(cols) * PW'(cols) * PW'(chans) * PW'(batch);
    endfunction

    assign total_full   = layer_words(fd_in_cols, fd_chans_per_mem, batch_q);
    assign oversize     = total_full > MAX_WORDS;
    assign accept       = (state == S_IDLE) && cfg_valid;
    assign words_loaded = wr_cnt;

    // A read is only issued with the skid empty, so at most one word is ever
    // caught by a full that rises while that read is in flight.
    assign src_rd_en      = (state == S_LOAD) && (rd_cnt < total) && !fd_ram_full && !skid_vld_p1;
    assign src_addr       = src_rd_en ? (base_q + rd_cnt[ADDR_WIDTH-1:0]) : '0;
    // Writes are confined to LOAD so a read still in flight when the layer
    // aborts is dropped rather than written.
    assign fd_valid_write = (state == S_LOAD) && (rd_vld_p1 || skid_vld_p1) && !fd_ram_full;
    assign fd_data_in     = !fd_valid_write ? '0 : (skid_vld_p1 ? skid_data_p1 : src_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        fd_start   = 1'b0;
        case (state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) next_state = S_SETUP;
            end
            S_SETUP: begin
                if ((total_full == '0) || oversize) next_state = S_DONE;
                else                                next_state = S_LOAD;
            end
            S_LOAD: begin
                fd_start = 1'b1;
                if (fd_last_out)                                 next_state = S_DONE;
                else if ((wr_cnt + CW'(fd_valid_write)) == total) next_state = S_WAIT;
            end
            S_WAIT: begin
                fd_start = 1'b1;
                if (fd_last_out) next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fd_stride        <= '0;
            fd_chans_per_mem <= '0;
            fd_in_cols       <= '0;
            fd_k_dimension   <= '0;
            fd_o_dimension   <= '0;
            batch_q          <= '0;
            base_q           <= '0;
            total            <= '0;
            rd_cnt           <= '0;
            wr_cnt           <= '0;
            err              <= 1'b0;
            rd_vld_p1        <= 1'b0;
            skid_vld_p1      <= 1'b0;
        end else begin
            if (accept) begin
                fd_stride        <= cfg_stride;
                fd_chans_per_mem <= cfg_chans;
                fd_in_cols       <= cfg_in_cols;
                fd_k_dimension   <= cfg_k;
                fd_o_dimension   <= cfg_o;
                batch_q          <= cfg_batch;
                base_q           <= cfg_base;
                total            <= '0;
                rd_cnt           <= '0;
                wr_cnt           <= '0;
                err              <= 1'b0;
            end
            if (state == S_SETUP) begin
                total <= oversize ? '0 : total_full[CW-1:0];
                if (oversize) err <= 1'b1;
            end
            if (src_rd_en)      rd_cnt <= rd_cnt + 1'b1;
            if (fd_valid_write) wr_cnt <= wr_cnt + 1'b1;
            if ((state == S_LOAD) && fd_last_out) err <= 1'b1;

            // stage p1: read data returns one cycle after the request
            rd_vld_p1 <= src_rd_en;
            if (state != S_LOAD)                   skid_vld_p1 <= 1'b0;
            else if (skid_vld_p1 && !fd_ram_full)  skid_vld_p1 <= 1'b0;
            else if (rd_vld_p1 && fd_ram_full)     skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_vld_p1 && fd_ram_full && !skid_vld_p1) skid_data_p1 <= src_data;
    end

endmodule
